// File: rtl/bcd_counter.sv
// Multi-digit BCD up/down counter with a built-in prescaler.
// Produces a packed BCD digit vector (digit 0 in bits [3:0]) plus tick, wrap and terminal-count
// flags for chaining counters.
// Optional feature macro: BCD_CNT_SATURATE_EN makes the counter hold at all-9 (up) or all-0 (down)
// instead of wrapping around.
module bcd_counter #(
  parameter int unsigned NUM_BCDS   = 2,
  parameter int unsigned PRESCALE   = 1000,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  clr,
  input  logic                  load,
  input  logic [NUM_BCDS*4-1:0] load_val,
  output logic [NUM_BCDS*4-1:0] bcd_out,
  output logic                  tick,
  output logic                  wrap,
  output logic                  tc
);

  localparam int unsigned           W        = NUM_BCDS * 4;
  localparam logic [PRESCALE_W-1:0] PresLast = PRESCALE_W'(PRESCALE - 1);

  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [W-1:0]          bcd_q, bcd_d;
  logic                  tick_q, tick_d;
  logic                  wrap_q, wrap_d;

  logic         step;
  logic         all9, all0;
  logic [W-1:0] stepped;
  logic [W-1:0] sanitised;

  // Step fires on the last prescaler phase of an enabled cycle.
  always_comb begin
    step = en && (presc_q == PresLast);
  end

  // Digit-wise increment/decrement with ripple carry/borrow, plus end-of-range detection.
  always_comb begin
    logic       carry;
    logic [3:0] digit;
    carry   = 1'b1;
    all9    = 1'b1;
    all0    = 1'b1;
    stepped = bcd_q;
    for (int i = 0; i < NUM_BCDS; i++) begin
      digit = bcd_q[i*4 +: 4];
      all9  = all9 & (digit == 4'd9);
      all0  = all0 & (digit == 4'd0);
      if (carry) begin
        if (up_dn) begin
          stepped[i*4 +: 4] = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
        end else begin
          stepped[i*4 +: 4] = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
        end
      end
      carry = carry & (up_dn ? (digit == 4'd9) : (digit == 4'd0));
    end
  end

  // Load values above 9 become 0 so the digits never leave BCD range.
  always_comb begin
    sanitised = '0;
    for (int i = 0; i < NUM_BCDS; i++) begin
      sanitised[i*4 +: 4] = (load_val[i*4 +: 4] > 4'd9) ? 4'd0 : load_val[i*4 +: 4];
    end
  end

  // Next-state: clr over load over step; reset is applied in the register block.
  always_comb begin
    logic at_end;
    bcd_d   = bcd_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    at_end  = up_dn ? all9 : all0;
    if (clr) begin
      bcd_d   = '0;
      presc_d = '0;
    end else if (load) begin
      bcd_d   = sanitised;
      presc_d = '0;
    end else if (step) begin
      presc_d = '0;
      tick_d  = 1'b1;
`ifdef BCD_CNT_SATURATE_EN
      if (!at_end) begin
        bcd_d = stepped;
      end
`else
      bcd_d  = stepped;
      wrap_d = at_end;
`endif
    end else if (en) begin
      presc_d = presc_q + 1'b1;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      bcd_q   <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      bcd_q   <= bcd_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  // Outputs; tc tracks up_dn combinationally.
  always_comb begin
    bcd_out = bcd_q;
    tick    = tick_q;
    wrap    = wrap_q;
    tc      = up_dn ? all9 : all0;
  end

endmodule

// File: tb/tb_bcd_counter.sv
// Directed self-checking bench for bcd_counter (NUM_BCDS=2, PRESCALE=4).
// Honours BCD_CNT_SATURATE_EN to select the expected end-of-range behaviour.
module tb_bcd_counter;

  logic       clk = 1'b0;
  logic       rst, en, up_dn, clr, load;
  logic [7:0] load_val;
  logic [7:0] bcd_out;
  logic       tick, wrap, tc;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_counter #(
    .NUM_BCDS  (2),
    .PRESCALE  (4),
    .PRESCALE_W(16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .up_dn   (up_dn),
    .clr     (clr),
    .load    (load),
    .load_val(load_val),
    .bcd_out (bcd_out),
    .tick    (tick),
    .wrap    (wrap),
    .tc      (tc)
  );

  always #5 clk = ~clk;

  // Advance n rising edges; return 1 time unit after the last one.
  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic sat;
`ifdef BCD_CNT_SATURATE_EN
    sat = 1'b1;
`else
    sat = 1'b0;
`endif
    rst = 1'b1; en = 1'b1; up_dn = 1'b1; clr = 1'b0; load = 1'b0; load_val = 8'h00;
    cyc(2);
    check("rst_bcd", bcd_out, 8'h00);
    check("rst_tick", {7'd0, tick}, 8'd0);
    check("rst_wrap", {7'd0, wrap}, 8'd0);

    // First step on the 4th edge after reset falls.
    rst = 1'b0;
    cyc(3);
    check("pre_step_bcd", bcd_out, 8'h00);
    check("pre_step_tick", {7'd0, tick}, 8'd0);
    cyc(1);
    check("step1_bcd", bcd_out, 8'h01);
    check("step1_tick", {7'd0, tick}, 8'd1);
    cyc(1);
    check("step1_tick_drop", {7'd0, tick}, 8'd0);
    cyc(3);
    check("step2_bcd", bcd_out, 8'h02);
    check("step2_tick", {7'd0, tick}, 8'd1);

    // Carry up 09 -> 10.
    load = 1'b1; load_val = 8'h09;
    cyc(1);
    load = 1'b0;
    check("load09", bcd_out, 8'h09);
    check("load09_tc", {7'd0, tc}, 8'd0);
    cyc(4);
    check("carry_bcd", bcd_out, 8'h10);
    check("carry_wrap", {7'd0, wrap}, 8'd0);

    // Up wrap from 99.
    load = 1'b1; load_val = 8'h99;
    cyc(1);
    load = 1'b0;
    check("load99_tc", {7'd0, tc}, 8'd1);
    cyc(3);
    check("at99_tick", {7'd0, tick}, 8'd0);
    cyc(1);
    check("wrapup_bcd", bcd_out, sat ? 8'h99 : 8'h00);
    check("wrapup_wrap", {7'd0, wrap}, sat ? 8'd0 : 8'd1);
    check("wrapup_tick", {7'd0, tick}, 8'd1);
    cyc(1);
    check("wrapup_wrap_drop", {7'd0, wrap}, 8'd0);
    check("wrapup_tick_drop", {7'd0, tick}, 8'd0);
    cyc(3);
    check("after_wrap_bcd", bcd_out, sat ? 8'h99 : 8'h01);
    check("after_wrap_tick", {7'd0, tick}, 8'd1);

    // Borrow down 10 -> 09.
    up_dn = 1'b0;
    load = 1'b1; load_val = 8'h10;
    cyc(1);
    load = 1'b0;
    check("load10_tc", {7'd0, tc}, 8'd0);
    cyc(4);
    check("borrow_bcd", bcd_out, 8'h09);

    // Down wrap from 00.
    load = 1'b1; load_val = 8'h00;
    cyc(1);
    load = 1'b0;
    check("load00_tc", {7'd0, tc}, 8'd1);
    cyc(4);
    check("wrapdn_bcd", bcd_out, sat ? 8'h00 : 8'h99);
    check("wrapdn_wrap", {7'd0, wrap}, sat ? 8'd0 : 8'd1);

    // tc follows up_dn combinationally.
    load = 1'b1; load_val = 8'h99;
    cyc(1);
    load = 1'b0;
    check("tc_dn_at99", {7'd0, tc}, 8'd0);
    up_dn = 1'b1;
    #1;
    check("tc_up_at99", {7'd0, tc}, 8'd1);

    // Sanitising and priority.
    load = 1'b1; load_val = 8'h5C;
    cyc(1);
    check("sanitise", bcd_out, 8'h50);
    clr = 1'b1; load_val = 8'h57;
    cyc(1);
    clr = 1'b0; load = 1'b0;
    check("clr_over_load", bcd_out, 8'h00);
    cyc(3);
    load = 1'b1; load_val = 8'h23;
    cyc(1);
    load = 1'b0;
    check("load_over_step_bcd", bcd_out, 8'h23);
    check("load_over_step_tick", {7'd0, tick}, 8'd0);
    cyc(3);
    check("post_load_no_tick", {7'd0, tick}, 8'd0);
    cyc(1);
    check("post_load_step", bcd_out, 8'h24);

    // en gating: freeze at phase 2 for 10 cycles.
    cyc(2);
    en = 1'b0;
    cyc(10);
    check("frozen_bcd", bcd_out, 8'h24);
    check("frozen_tick", {7'd0, tick}, 8'd0);
    en = 1'b1;
    cyc(1);
    check("resume_no_tick", {7'd0, tick}, 8'd0);
    cyc(1);
    check("resume_step_bcd", bcd_out, 8'h25);
    check("resume_step_tick", {7'd0, tick}, 8'd1);

    // Reset mid-count.
    cyc(2);
    rst = 1'b1;
    cyc(1);
    check("midrst_bcd", bcd_out, 8'h00);
    check("midrst_tick", {7'd0, tick}, 8'd0);
    rst = 1'b0;
    cyc(4);
    check("after_midrst_bcd", bcd_out, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_counter.md
# bcd_counter

Multi-digit decimal (BCD) up/down counter with a built-in prescaler. It produces the packed BCD digit vector consumed by the 7-segment display decoder directly downstream. It supports synchronous clear, parallel load, count enable and direction control. It flags terminal count and wrap-around so top-level logic can chain counters or raise events.

## Interface
- NUM_BCDS, 2, number of BCD digits; digit 0 is the least significant, in bits [3:0].
- PRESCALE, 1000, clk cycles per count step while enabled; legal range 1 to 2^PRESCALE_W-1.
- PRESCALE_W, 16, width of the internal prescaler counter.

- clk  input  1  system clock, all logic on the rising edge.
- rst  input  1  reset: one clock, synchronous, active-high.
- en  input  1  count enable; low freezes both the prescaler and the digits.
- up_dn  input  1  direction: 1 counts up, 0 counts down; sampled only in a step cycle.
- clr  input  1  synchronous clear of digits and prescaler.
- load  input  1  synchronous parallel load of load_val.
- load_val  input  NUM_BCDS*4  BCD value to load.
- bcd_out  output  NUM_BCDS*4  registered BCD count.
- tick  output  1  registered one-cycle pulse, high in the cycle bcd_out shows a stepped value.
- wrap  output  1  registered one-cycle pulse on wrap-around (99..9→00..0 or 00..0→99..9).
- tc  output  1  terminal count, decoded from registers: (up_dn && bcd_out==all 9) || (!up_dn && bcd_out==all 0).

## Operation
- Priority, highest first: rst, clr, load, step.
- rst: bcd_out=0, prescaler=0, tick=0, wrap=0.
- clr (rst low): bcd_out=0 and prescaler=0. tick and wrap are 0.
- load (rst and clr low): each digit takes its load_val nibble. A nibble above 9 loads as 0. Prescaler is set to 0; tick and wrap are 0.
- Prescaler, when none of rst, clr or load is active:
  - en=1: counts 0..PRESCALE-1.
  - step = en && prescaler==PRESCALE-1; on a step the prescaler returns to 0.
  - PRESCALE=1: every enabled cycle is a step.
  - en=0: prescaler holds its value and no step occurs.
- Step up:
  - Digit 0 increments.
  - Digit i>0 increments only when all lower digits are 9.
  - A digit at 9 that increments becomes 0.
- Step down:
  - Digit 0 decrements.
  - Digit i>0 decrements only when all lower digits are 0.
  - A digit at 0 that decrements becomes 9.
- Wrap: a step up from all 9 gives all 0, and a step down from all 0 gives all 9. wrap=1 in the same cycle as the new value.
- Every step asserts tick for exactly one cycle.
- Non-BCD state is unreachable, because load sanitises its input.

## Timing
- Step latency: a step condition at edge N puts the new bcd_out, tick and wrap on edge N. All three are valid for one cycle after edge N; tick and wrap drop on edge N+1 unless another step occurs.
- Load/clear latency: asserted before edge N, visible after edge N. A step due on the same edge is discarded.
- Step period: with en held high, tick pulses every PRESCALE cycles. The first pulse arrives PRESCALE cycles after reset, clr or load deasserts.
- Direction: an up_dn change takes effect at the next step. tc follows up_dn combinationally.
- Mid-operation reset: the next edge forces all reset values regardless of the prescaler phase.
- Display path: the downstream decoder adds one register stage, so a digit change reaches the segments one cycle after bcd_out.

## Configuration
- BCD_CNT_SATURATE_EN:
  - Defined: a step up at all 9, or a step down at all 0, leaves bcd_out unchanged. wrap stays 0. tick still pulses and the prescaler still reloads.
  - Undefined: wrap-around as described in Operation.

## Test plan
- Reset with NUM_BCDS=2, PRESCALE=4, en=1, up_dn=1: bcd_out=0x00 and tick=0 during rst. Then bcd_out=0x01 with tick=1 on the 4th edge after rst falls, and 0x02 four cycles later.
- Carry and wrap (up): load 0x09, then one step gives 0x10 with wrap=0. Load 0x99, then one step gives 0x00 with wrap=1 and tick=1 for one cycle; tc=1 while the value is 0x99.
- Borrow and wrap (down), up_dn=0: load 0x10, then one step gives 0x09. Load 0x00, then one step gives 0x99 with wrap=1; tc=1 at 0x00.
- Load sanitising and priority:
  - load_val=0x5C gives 0x50.
  - clr=1 and load=1 together with 0x57 give 0x00.
  - load coinciding with a step gives load_val and tick=0.
- en gating: drop en for 10 cycles mid-prescale; bcd_out and phase are frozen. Re-raise en; the step arrives after the remaining prescale count.
- With BCD_CNT_SATURATE_EN: at 0x99 with up_dn=1, bcd_out stays 0x99 and wrap=0 while tick pulses every 4 cycles. Reset mid-count gives 0x00 on the next edge.
